immediate_pipe_unit: RTL

//  Decode-stage immediate generator, registered and flow-controlled. Accepts one
//  RV32I instruction word per cycle (valid/ready), produces the sign-extended

---
 rtl/immediate_pipe_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/immediate_pipe_unit.sv
// Registered, flow-controlled RV32I immediate generator with a 2-entry skid buffer.
// Optional feature macro: IMM_ILLEGAL_DETECT_EN (flags unrecognised opcodes on out_illegal).
module immediate_pipe_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_R    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    entry_t head_q, head_d, skid_q, skid_d, dec_entry;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;

    logic [6:0]      opcode;
    logic            sgn;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic            accept;
    logic            head_leave;

    assign opcode = in_instr[6:0];
    assign sgn    = in_instr[31];

    // Immediate extraction and format classification of the incoming word
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                dec_imm = {{(XLEN-11){sgn}}, in_instr[30:20]};
                dec_fmt = FMT_I;
            end
            7'b0100011: begin
                dec_imm = {{(XLEN-11){sgn}}, in_instr[30:25], in_instr[11:7]};
                dec_fmt = FMT_S;
            end
            7'b1100011: begin
                dec_imm = {{(XLEN-12){sgn}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm = {{(XLEN-31){sgn}}, in_instr[30:12], 12'b0};
                dec_fmt = FMT_U;
            end
            7'b1101111: begin
                dec_imm = {{(XLEN-20){sgn}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            7'b0110011: begin
                dec_imm = '0;
                dec_fmt = FMT_R;
            end
            default: begin
                dec_imm = '0;
                dec_fmt = FMT_NONE;
            end
        endcase
`ifdef IMM_ILLEGAL_DETECT_EN
        dec_illegal = (dec_fmt == FMT_NONE) || (in_instr[1:0] != 2'b11);
        if (dec_illegal) begin
            dec_imm = '0;
            dec_fmt = FMT_NONE;
        end
`else
        dec_illegal = 1'b0;
`endif
    end

    assign dec_entry  = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag, illegal: dec_illegal};
    assign accept     = in_valid & in_ready_q;
    assign head_leave = head_valid_q & out_ready;

    // Head/skid next state: flush clears, otherwise FIFO refill from skid or input
    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (head_leave) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = accept;
                if (accept) skid_d = dec_entry;
            end else begin
                head_valid_d = accept;
                if (accept) head_d = dec_entry;
            end
        end else if (!head_valid_q) begin
            head_valid_d = accept;
            if (accept) head_d = dec_entry;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec_entry;
        end
    end

    // Entry storage; in_ready is held low through reset and tracks skid occupancy after
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = head_valid_q;
    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_tag     = head_q.tag;
    assign out_illegal = head_q.illegal;

endmodule
